// File: rtl/ins_mem_loader_if.sv
// Host byte-stream handshake between a program source and the loader.
interface ins_mem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/ins_mem_loader.sv
// Byte-stream program loader with an integrated byte-addressed instruction
// store. A header byte gives the word count N, followed by 4*N bytes that
// are written sequentially from address 0. The processor reads big-endian
// 32-bit instructions through a combinational port; busy stalls it while
// a load is in progress.
module ins_mem_loader #(
  parameter int unsigned DEPTH = 72,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  ins_mem_loader_if.slave        bus,
  input  logic [31:0]            Address,
  output logic [31:0]            Instruction,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CNT_W-1:0]       words_loaded
);

  localparam int unsigned PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned REM_W = CNT_W + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] wl_q, wl_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic             we;
  logic             accept;
  logic [REM_W-1:0] hdr_bytes;
  logic [7:0]       mem_q [DEPTH];

  assign accept    = bus.in_valid & rdy_q;
  assign hdr_bytes = REM_W'(bus.in_data) << 2;

  assign bus.in_ready  = rdy_q;
  assign busy          = rdy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_loaded  = wl_q;

  // Next-state logic for the load sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    wl_d    = wl_q;
    done_d  = done_q;
    err_d   = err_q;
    we      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HDR;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wl_d    = '0;
          ptr_d   = '0;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (hdr_bytes == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (32'(hdr_bytes) > 32'(DEPTH)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = S_LOAD;
            rem_d   = hdr_bytes;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          we    = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
          rem_d = rem_q - REM_W'(1);
          // rem counts down from a multiple of 4, so rem==..01 marks the 4th byte
          if (rem_q[1:0] == 2'd1) wl_d = wl_q + CNT_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_HDR) || (state_d == S_LOAD);
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      wl_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      wl_q    <= wl_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  // Instruction store: cleared on reset, one byte written per accepted data byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[ptr_q[PTR_W-1:0]] <= bus.in_data;
    end
  end

  // Big-endian fetch; each byte index is formed in 33 bits so high addresses never wrap.
  always_comb begin
    logic [32:0] idx;
    Instruction = '0;
    idx         = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = {1'b0, Address} + 33'(k);
      if (idx < 33'(DEPTH)) Instruction[8*(3-k) +: 8] = mem_q[idx[PTR_W-1:0]];
    end
  end

endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
Byte-stream program loader with integrated byte-addressed instruction store. It is the write-side counterpart of the instruction memory read path. A host streams a 1-byte word-count header followed by 4·N instruction bytes (MSB-first per instruction) over a valid/ready handshake. The block writes them into a DEPTH-byte array; the processor fetches 32-bit big-endian instructions from the same array through a combinational read port. The `busy` output holds the processor in stall until the load completes.

Parameters:
- DEPTH, 72, storage size in bytes (must be a multiple of 4, max 1020).
- CNT_W, 8, width of the header word count and of `words_loaded`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a new load.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts a byte this cycle.
- Address  input  32  fetch byte address.
- Instruction  output  32  {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
- busy  output  1  load in progress (HDR or LOAD state).
- done  output  1  last load completed successfully.
- error  output  1  last header exceeded capacity.
- words_loaded  output  CNT_W  complete instructions written in the current load.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - state=IDLE; in_ready=0, busy=0, done=0, error=0, words_loaded=0.
  - Write pointer=0; all DEPTH bytes cleared to 0.
  - Applies from any state, including mid-load; the partial program is discarded.
- A byte is accepted only on a cycle with in_valid=1 and in_ready=1. At most one byte is accepted per cycle.
- in_ready is a registered output: 1 exactly in HDR and LOAD, 0 elsewhere. busy is identical to in_ready.
- States:
  - IDLE / DONE / ERROR:
    - start=1 → HDR on the next edge; clears done, error, words_loaded and the pointer.
    - Memory is not cleared by start.
    - in_valid is ignored.
  - HDR: on accept, N=in_data.
    - N=0 → DONE (done=1, nothing written).
    - 4·N > DEPTH → ERROR (error=1, memory untouched).
    - Otherwise → LOAD with remaining=4·N. Compute remaining in ≥ CNT_W+2 bits; no truncation.
  - LOAD: each accepted byte performs mem[ptr]←in_data, ptr←ptr+1, remaining←remaining−1.
    - words_loaded increments on every 4th accepted byte.
    - When the byte with remaining=1 is accepted → DONE; done=1 from the next cycle.
- start asserted in HDR or LOAD is ignored; the load continues.
- A written byte is visible on Instruction in the cycle after its acceptance edge. Writes are synchronous; there is no bypass.
- Read port:
  - Purely combinational from Address and the current contents.
  - Byte k (k=0..3) comes from index Address+k, computed in 33 bits so there is no wrap-around.
  - Any byte whose index ≥ DEPTH reads 0, so out-of-range fetches return 0.
  - Reads during LOAD return partial contents without stalling.
- Bytes beyond 4·N retain their previous contents; no clearing.

Test Plan:
- Nominal load: after reset, pulse start; send 0x02, then 8C 01 00 04, 00 22 18 20.
  - in_ready is 1 from the cycle after start.
  - done rises 1 cycle after the 9th accept; words_loaded=2; busy=0.
  - Address=0 → 0x8C010004; Address=4 → 0x00221820.
- Backpressure gaps: same stream with in_valid deasserted on random cycles → identical final memory and done. Bytes offered while in_valid=0 are not written.
- Capacity: header 0x12 (72 bytes) is accepted and fills memory; Address=68 returns the last word. Header 0x13 → error=1 next cycle; in_ready=0; memory unchanged.
- Boundary reads: after the full load, Address=70 → {mem[70], mem[71], 0x00, 0x00}; Address=0xFFFFFFFE → 0x00000000.
- Reset mid-load: rst after 5 data bytes → next cycle busy=0, in_ready=0, words_loaded=0; every Address reads 0x00000000. A new start/load then completes normally.
- Zero header / ignored start: header 0x00 → done=1 with no writes. start pulsed during LOAD does not restart it; pointer and words_loaded continue.
